load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Memory access stage fed by the datapath address/data select muxes; consumes the selected address and store data.
//  Latches one load/store request and drives the word-addressed memory handshake until mem_resp.
//  Returns aligned, sign/zero-extended load data to the write-back select mux.
//  Provides byte enables and lane-replicated store data for sub-word stores.
// PARAMETERS
//  ADDR_W   32  request/memory address width
//  DATA_W   32  data width; fixed at 32 (4 byte lanes), other values unsupported
// PORTS
//  clk              in   1       rising-edge clock
//  rst_n            in   1       reset, asynchronous, active-low
//  req_valid        in   1       request present
//  req_ready        out  1       unit can accept; high only in IDLE
//  req_write        in   1       1=store, 0=load
//  req_funct3       in   3       RV32I size/sign code (LB0 LH1 LW2 LBU4 LHU5; SB0 SH1 SW2)
//  req_addr         in   ADDR_W  byte address
//  req_wdata        in   DATA_W  store data, LSB-justified
//  rsp_valid        out  1       one-cycle pulse: access complete
//  rsp_rdata        out  DATA_W  extended load data; 0 for stores; held until next accept
//  rsp_err          out  1       misaligned-request flag (valid with rsp_valid)
//  mem_read         out  1       memory read strobe
//  mem_write        out  1       memory write strobe
//  mem_address      out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
//  mem_wdata        out  DATA_W  lane-replicated store data
//  mem_byte_enable  out  4       active lanes
//  mem_rdata        in   DATA_W  read data, valid with mem_resp
//  mem_resp         in   1       memory completes current access
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE; req_ready=1; rsp_valid=0; rsp_err=0; rsp_rdata=0; mem_read=mem_write=0; mem_address=0; mem_wdata=0; mem_byte_enable=0.
//  - FSM: IDLE -> ACCESS on req_valid&&req_ready (accept); ACCESS -> DONE on mem_resp; DONE -> IDLE unconditionally.
//  - Accept cycle T: latch write, funct3, addr, wdata. In ACCESS, mem_read (load) or mem_write (store) is held high with stable address/data/enables until mem_resp.
//  - Minimum latency: mem_resp at T+1 -> rsp_valid at T+2; accept again earliest T+3.
//  - req_valid in ACCESS/DONE is ignored (req_ready=0). mem_resp outside ACCESS is ignored.
//  - Byte enables: byte=4'b0001<<addr[1:0]; half=4'b0011<<{addr[1],1'b0}; word=4'b1111. Loads and stores use the same rule.
//  - Store data: byte={4{wdata[7:0]}}; half={2{wdata[15:0]}}; word=wdata.
//  - Load data: lanes = mem_rdata >> (8*addr[1:0]), half uses addr[1] only. LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW raw. Captured on the mem_resp cycle into rsp_rdata.
//  - Undefined funct3 (loads 3,6,7; stores 3..7) is treated as a word access.
//  - Misaligned (half with addr[0]=1; word with addr[1:0]!=0), macro absent: the low address bits are dropped and the access proceeds aligned down.
//  - Reset mid-ACCESS: strobes drop asynchronously, the request is lost, and no rsp_valid is issued.
// CONFIGURATION
//  LSU_MISALIGN_CHECK_EN defined: a misaligned request goes IDLE -> DONE with no memory strobe; rsp_err=1 and rsp_rdata=0 with rsp_valid, so rsp_valid appears one cycle after accept.
//  LSU_MISALIGN_CHECK_EN undefined: rsp_err is tied 0 and misaligned requests align down as above.
// STRUCTURE
//  lsu_pkg: funct3 enums (lsu_load_e, lsu_store_e), lsu_state_e {IDLE,ACCESS,DONE}, and lane-count constant.
//  Sub-module lsu_align (combinational): computes byte enables, replicated store data and extracted/extended load data from funct3 and addr[1:0].
//  Top level holds the FSM and the request/response registers only.
// TESTING
//  1 LW addr 0x100, mem_resp 1 cycle later with rdata 0xDEADBEEF -> mem_address 0x100, be 4'hF, rsp_rdata 0xDEADBEEF, rsp_valid at T+2.
//  2 LB addr 0x103, rdata 0x80FF_0000 -> be 4'b1000, rsp_rdata 0xFFFFFF80; LBU at the same address -> 0x00000080.
//  3 SH addr 0x206, wdata 0x1234ABCD -> mem_write, address 0x204, be 4'b1100, mem_wdata 0xABCDABCD, rsp_rdata 0.
//  4 mem_resp delayed 5 cycles, req_valid held high -> strobes and address stable, req_ready=0 until back in IDLE, exactly one rsp_valid.
//  5 rst_n low during ACCESS -> mem_read drops the same cycle, state IDLE, no rsp_valid; the next request completes normally.
//  6 LH addr 0x101: without the macro -> address 0x100, be 4'b0011. With LSU_MISALIGN_CHECK_EN -> no strobe, rsp_err=1 at T+1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: RV32I funct3 codes, FSM states and access-size decode.
// Imported by lsu_align and load_store_unit.
package lsu_pkg;

    localparam int LSU_LANES  = 4;
    localparam int LSU_DATA_W = LSU_LANES * 8;

    typedef enum logic [2:0] {
        LD_LB  = 3'd0,
        LD_LH  = 3'd1,
        LD_LW  = 3'd2,
        LD_LBU = 3'd4,
        LD_LHU = 3'd5
    } lsu_load_e;

    typedef enum logic [2:0] {
        ST_SB = 3'd0,
        ST_SH = 3'd1,
        ST_SW = 3'd2
    } lsu_store_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } lsu_size_e;

    // Undefined funct3 codes fall through to a word access.
    function automatic lsu_size_e lsu_size(input logic write, input logic [2:0] funct3);
        lsu_size_e sz;
        sz = SZ_WORD;
        if (write) begin
            case (funct3)
                ST_SB:   sz = SZ_BYTE;
                ST_SH:   sz = SZ_HALF;
                default: sz = SZ_WORD;
            endcase
        end else begin
            case (funct3)
                LD_LB, LD_LBU: sz = SZ_BYTE;
                LD_LH, LD_LHU: sz = SZ_HALF;
                default:       sz = SZ_WORD;
            endcase
        end
        return sz;
    endfunction

    function automatic logic lsu_misaligned(input lsu_size_e sz, input logic [1:0] addr_lo);
        logic mis;
        case (sz)
            SZ_HALF: mis = addr_lo[0];
            SZ_WORD: mis = |addr_lo;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables, replicated store data and
// extracted, sign/zero-extended load data from funct3 and the low address bits.
module lsu_align
    import lsu_pkg::*;
(
    input  logic                  write,
    input  logic [2:0]            funct3,
    input  logic [1:0]            addr_lo,
    input  logic [LSU_DATA_W-1:0] st_wdata,
    input  logic [LSU_DATA_W-1:0] mem_rdata,
    output logic [LSU_LANES-1:0]  byte_enable,
    output logic [LSU_DATA_W-1:0] st_data,
    output logic [LSU_DATA_W-1:0] ld_data
);

    lsu_size_e             size;
    logic [LSU_DATA_W-1:0] shifted;
    logic                  sign_ext;

    assign size     = lsu_size(write, funct3);
    // funct3[2] marks the unsigned load variants.
    assign sign_ext = ~funct3[2];

    // NOTE: every output gets a default first so no path leaves a latch behind.
    always_comb begin
        byte_enable = 4'b1111;
        st_data     = st_wdata;
        shifted     = mem_rdata;
        ld_data     = mem_rdata;
        case (size)
            SZ_BYTE: begin
                byte_enable = 4'b0001 << addr_lo;
                st_data     = {4{st_wdata[7:0]}};
                shifted     = mem_rdata >> {addr_lo, 3'b000};
                ld_data     = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                byte_enable = 4'b0011 << {addr_lo[1], 1'b0};
                st_data     = {2{st_wdata[15:0]}};
                shifted     = mem_rdata >> {addr_lo[1], 4'b0000};
                ld_data     = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: latches one request, drives the word-addressed memory handshake,
// returns extended load data. Optional misalignment trap under LSU_MISALIGN_CHECK_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_byte_enable,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    lsu_state_e        state_q, state_d;
    logic              write_q, write_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              accept, mis_req, in_access;
    logic [3:0]        be_w;
    logic [DATA_W-1:0] st_data_w, ld_data_w;

    assign accept    = req_valid && req_ready;
    assign in_access = (state_q == ACCESS);

`ifdef LSU_MISALIGN_CHECK_EN
    logic err_q, err_d;

    assign mis_req = lsu_misaligned(lsu_size(req_write, req_funct3), req_addr[1:0]);
    assign err_d   = accept ? mis_req : err_q;
    assign rsp_err = (state_q == DONE) && err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end
`else
    assign mis_req = 1'b0;
    assign rsp_err = 1'b0;
`endif

    lsu_align u_align (
        .write       (write_q),
        .funct3      (funct3_q),
        .addr_lo     (addr_q[1:0]),
        .st_wdata    (wdata_q),
        .mem_rdata   (mem_rdata),
        .byte_enable (be_w),
        .st_data     (st_data_w),
        .ld_data     (ld_data_w)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = mis_req ? DONE : ACCESS;
            ACCESS:  if (mem_resp) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready       = (state_q == IDLE);
        rsp_valid       = (state_q == DONE);
        mem_read        = in_access && !write_q;
        mem_write       = in_access && write_q;
        mem_address     = in_access ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
        mem_wdata       = in_access ? st_data_w : '0;
        mem_byte_enable = in_access ? be_w : 4'b0000;
        rsp_rdata       = rdata_q;
    end

    // Response data clears on accept so stores and trapped requests report zero.
    always_comb begin
        write_d  = write_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        if (accept) begin
            write_d  = req_write;
            funct3_d = req_funct3;
            addr_d   = req_addr;
            wdata_d  = req_wdata;
            rdata_d  = '0;
        end else if (in_access && mem_resp && !write_q) begin
            rdata_d  = ld_data_w;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q  <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            write_q  <= write_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule
